// File: rtl/stream_memory_fetcher_if.sv
// stream_memory_fetcher_if
//   Bundles the fetcher's bus traffic: weight BRAM read port, bias BRAM read
//   port and the valid/ready beat stream toward the MAC array.
//   master : the fetcher (drives read requests and the output stream)
//   slave  : the environment (BRAMs answering reads, consumer driving out_ready)
interface stream_memory_fetcher_if #(
    parameter int BRAM_WIDTH     = 64,
    parameter int N              = 4,
    parameter int PRECISION      = 8,
    parameter int BIAS_PRECISION = 32,
    parameter int W_ADDR_W       = 12,
    parameter int B_ADDR_W       = 8
) ();
    logic                          w_en;
    logic [W_ADDR_W-1:0]           w_addr;
    logic [BRAM_WIDTH-1:0]         w_rdata;
    logic                          b_en;
    logic [B_ADDR_W-1:0]           b_addr;
    logic [BIAS_PRECISION-1:0]     b_rdata;
    logic                          out_valid;
    logic                          out_ready;
    logic [N-1:0][PRECISION-1:0]   out_data;
    logic [BIAS_PRECISION-1:0]     out_bias;
    logic                          out_first;
    logic                          out_last;

    modport master (
        output w_en, w_addr, b_en, b_addr,
        input  w_rdata, b_rdata,
        output out_valid, out_data, out_bias, out_first, out_last,
        input  out_ready
    );

    modport slave (
        input  w_en, w_addr, b_en, b_addr,
        output w_rdata, b_rdata,
        input  out_valid, out_data, out_bias, out_first, out_last,
        output out_ready
    );
endinterface

// File: rtl/stream_memory_fetcher.sv
// stream_memory_fetcher
//   Streams a rows x beats weight matrix out of a 1-cycle-latency BRAM,
//   BPW beats per BRAM word, pairing every beat with its row bias read from
//   a separate bias BRAM. Each job is launched by a start pulse carrying
//   the sizes and base addresses.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, cfg_*          job launch (sampled only when idle)
//   busy, done            job in progress / one-cycle completion pulse
//   bus (master)          weight/bias read ports and the output beat stream
module stream_memory_fetcher #(
    parameter int BRAM_WIDTH     = 64,
    parameter int N              = 4,
    parameter int PRECISION      = 8,
    parameter int BIAS_PRECISION = 32,
    parameter int MAX_M          = 64,
    parameter int MAX_BEATS      = 64,
    parameter int W_ADDR_W       = 12,
    parameter int B_ADDR_W       = 8,
    localparam int LANE_W        = N * PRECISION,
    localparam int BPW           = BRAM_WIDTH / LANE_W,
    localparam int ROW_W         = $clog2(MAX_M + 1),
    localparam int BEAT_W        = $clog2(MAX_BEATS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ROW_W-1:0]      cfg_rows,
    input  logic [BEAT_W-1:0]     cfg_beats,
    input  logic [W_ADDR_W-1:0]   cfg_w_base,
    input  logic [B_ADDR_W-1:0]   cfg_b_base,
    output logic                  busy,
    output logic                  done,
    stream_memory_fetcher_if.master bus
);
    localparam int TW  = ROW_W + BEAT_W;          // holds rows*beats
    localparam int LIW = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;
    state_t state, state_nx;

    logic [ROW_W-1:0]    rows_q, row_cnt, b_issued;
    logic [BEAT_W-1:0]   beats_q, beat_cnt;
    logic [TW-1:0]       words_q, w_issued, prod_c, words_c;
    logic [W_ADDR_W-1:0] w_base_q;
    logic [B_ADDR_W-1:0] b_base_q;
    logic [LIW-1:0]      lane_cnt;

    // Two-entry word/bias FIFOs; *_pend marks a read whose data lands next cycle.
    logic [BRAM_WIDTH-1:0]     w_mem [2];
    logic                      w_wp, w_rp, w_pend;
    logic [1:0]                w_cnt;
    logic [BIAS_PRECISION-1:0] b_mem [2];
    logic                      b_wp, b_rp, b_pend;
    logic [1:0]                b_cnt;

    logic start_ok, hs, row_end, is_last, w_pop, b_pop, w_issue, b_issue, valid;

    assign start_ok = (state == S_IDLE) && start;
    assign prod_c   = TW'(cfg_rows) * TW'(cfg_beats);
    assign words_c  = (prod_c + TW'(BPW - 1)) / TW'(BPW);

    assign valid    = (state == S_RUN) && (w_cnt != 2'd0) && (b_cnt != 2'd0);
    assign hs       = valid && bus.out_ready;
    assign row_end  = (beat_cnt == beats_q - BEAT_W'(1));
    assign is_last  = row_end && (row_cnt == rows_q - ROW_W'(1));
    // A word leaves once its last lane goes out; the job's final beat also
    // retires the last word even when trailing lanes are unused.
    assign w_pop    = hs && ((lane_cnt == LIW'(BPW - 1)) || is_last);
    assign b_pop    = hs && row_end;

    // Credit: buffered + in-flight must stay below 2, a same-cycle pop frees one.
    assign w_issue  = (state == S_RUN) && (w_issued < words_q) &&
                      ((3'(w_cnt) + 3'(w_pend)) < (3'd2 + 3'(w_pop)));
    assign b_issue  = (state == S_RUN) && (b_issued < rows_q) &&
                      ((3'(b_cnt) + 3'(b_pend)) < (3'd2 + 3'(b_pop)));

    assign bus.w_en      = w_issue;
    assign bus.w_addr    = w_issue ? w_base_q + W_ADDR_W'(w_issued) : '0;
    assign bus.b_en      = b_issue;
    assign bus.b_addr    = b_issue ? b_base_q + B_ADDR_W'(b_issued) : '0;
    assign bus.out_valid = valid;
    assign bus.out_data  = valid ? w_mem[w_rp][lane_cnt*LANE_W +: LANE_W] : '0;
    assign bus.out_bias  = valid ? b_mem[b_rp] : '0;
    assign bus.out_first = valid && (beat_cnt == '0);
    assign bus.out_last  = valid && is_last;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_FINISH);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = (cfg_rows != '0 && cfg_beats != '0) ? S_RUN : S_FINISH;
            S_RUN:    if (hs && is_last) state_nx = S_FINISH;
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Job configuration and sequencing counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_q <= '0; beats_q <= '0; words_q <= '0;
            w_base_q <= '0; b_base_q <= '0;
            w_issued <= '0; b_issued <= '0;
            row_cnt <= '0; beat_cnt <= '0; lane_cnt <= '0;
        end else if (start_ok) begin
            rows_q <= cfg_rows; beats_q <= cfg_beats; words_q <= words_c;
            w_base_q <= cfg_w_base; b_base_q <= cfg_b_base;
            w_issued <= '0; b_issued <= '0;
            row_cnt <= '0; beat_cnt <= '0; lane_cnt <= '0;
        end else begin
            if (w_issue) w_issued <= w_issued + TW'(1);
            if (b_issue) b_issued <= b_issued + ROW_W'(1);
            if (hs) begin
                if (row_end) begin
                    beat_cnt <= '0;
                    row_cnt  <= row_cnt + ROW_W'(1);
                end else begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                end
                // Lanes run straight across row boundaries (rows may start mid-word).
                lane_cnt <= w_pop ? '0 : lane_cnt + LIW'(1);
            end
        end
    end

    // FIFOs: reset drops pending reads, so data returning after reset is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_mem[0] <= '0; w_mem[1] <= '0;
            w_wp <= 1'b0; w_rp <= 1'b0; w_cnt <= '0; w_pend <= 1'b0;
            b_mem[0] <= '0; b_mem[1] <= '0;
            b_wp <= 1'b0; b_rp <= 1'b0; b_cnt <= '0; b_pend <= 1'b0;
        end else begin
            w_pend <= w_issue;
            if (w_pend) begin
                w_mem[w_wp] <= bus.w_rdata;
                w_wp        <= ~w_wp;
            end
            if (w_pop) w_rp <= ~w_rp;
            w_cnt <= w_cnt + 2'(w_pend) - 2'(w_pop);

            b_pend <= b_issue;
            if (b_pend) begin
                b_mem[b_wp] <= bus.b_rdata;
                b_wp        <= ~b_wp;
            end
            if (b_pop) b_rp <= ~b_rp;
            b_cnt <= b_cnt + 2'(b_pend) - 2'(b_pop);
        end
    end
endmodule

// File: tb/tb_stream_memory_fetcher.sv
module tb_stream_memory_fetcher;
    localparam int BRAM_WIDTH = 64, N = 4, PRECISION = 8, BIAS_PRECISION = 32;
    localparam int MAX_M = 64, MAX_BEATS = 64, W_ADDR_W = 12, B_ADDR_W = 8;
    localparam int LANE_W = N * PRECISION;
    localparam int BPW    = BRAM_WIDTH / LANE_W;
    localparam int ROW_W  = $clog2(MAX_M + 1);
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [ROW_W-1:0]    cfg_rows = '0;
    logic [BEAT_W-1:0]   cfg_beats = '0;
    logic [W_ADDR_W-1:0] cfg_w_base = '0;
    logic [B_ADDR_W-1:0] cfg_b_base = '0;
    logic busy, done;

    stream_memory_fetcher_if #(.BRAM_WIDTH(BRAM_WIDTH), .N(N), .PRECISION(PRECISION),
        .BIAS_PRECISION(BIAS_PRECISION), .W_ADDR_W(W_ADDR_W), .B_ADDR_W(B_ADDR_W)) bus ();

    stream_memory_fetcher #(.BRAM_WIDTH(BRAM_WIDTH), .N(N), .PRECISION(PRECISION),
        .BIAS_PRECISION(BIAS_PRECISION), .MAX_M(MAX_M), .MAX_BEATS(MAX_BEATS),
        .W_ADDR_W(W_ADDR_W), .B_ADDR_W(B_ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_rows(cfg_rows), .cfg_beats(cfg_beats),
        .cfg_w_base(cfg_w_base), .cfg_b_base(cfg_b_base), .busy(busy), .done(done), .bus(bus));

    initial forever #5 clk = ~clk;

    // BRAM models: one-cycle read latency
    logic [BRAM_WIDTH-1:0] wmem [4096];
    logic [31:0]           bmem [256];
    always @(posedge clk) begin
        if (bus.w_en) bus.w_rdata <= wmem[bus.w_addr];
        if (bus.b_en) bus.b_rdata <= bmem[bus.b_addr];
    end

    int n_chk = 0, n_pass = 0;
    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    typedef struct { logic [LANE_W-1:0] data; logic [31:0] bias; bit first; bit last; } beat_t;
    beat_t exp_q[$], hs_log[$], bp_log[$];
    int waddr_log[$], baddr_log[$];

    int  cyc = 0, c0 = 0;
    bit  chk_on = 0, rnd_ready = 0, done_pend = 0, stall = 0;
    int  job_wb, job_bb, job_words, job_rows, job_beats;
    int  n_wr, n_br, n_hs, first_rel, done_rel;
    beat_t held;

    always @(posedge clk) cyc++;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Reference: beat g of a job comes from word wb + g/BPW, lane g%BPW,
    // with the bias of row g/beats.
    function automatic void build(int rows, int beats, int wb, int bb);
        exp_q.delete();
        for (int g = 0; g < rows * beats; g++) begin
            beat_t e;
            logic [BRAM_WIDTH-1:0] w;
            w       = wmem[(wb + g / BPW) % 4096];
            e.data  = w[(g % BPW) * LANE_W +: LANE_W];
            e.bias  = bmem[(bb + g / beats) % 256];
            e.first = (g % beats) == 0;
            e.last  = (g == rows * beats - 1);
            exp_q.push_back(e);
        end
    endfunction

    // Single compare process: stream contents, stall stability, read
    // addresses, read bounds/credits and the done pulse.
    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            int rel;
            bit hs_now;
            beat_t act;
            rel = cyc - c0 + 1;
            act.data = bus.out_data; act.bias = bus.out_bias;
            act.first = bus.out_first; act.last = bus.out_last;
            chk("done", done, done_pend);
            if (done && done_rel < 0) done_rel = rel;
            done_pend = 0;
            if (stall) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", act.data, held.data);
                chk("stall_bias", act.bias, held.bias);
                chk("stall_flags", {act.first, act.last}, {held.first, held.last});
            end
            hs_now = bus.out_valid && bus.out_ready;
            if (bus.out_valid) begin
                if (first_rel < 0) first_rel = rel;
                if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
                else begin
                    chk("out_data", act.data, exp_q[0].data);
                    chk("out_bias", act.bias, exp_q[0].bias);
                    chk("out_first", act.first, exp_q[0].first);
                    chk("out_last", act.last, exp_q[0].last);
                end
            end
            if (bus.w_en) begin
                chk("w_addr", bus.w_addr, (job_wb + n_wr) % 4096);
                waddr_log.push_back(int'(bus.w_addr));
                n_wr++;
                chk("w_bound", n_wr <= job_words, 1);
                chk("w_credit", (n_wr - (n_hs + int'(hs_now)) / BPW) <= 2, 1);
            end
            if (bus.b_en) begin
                chk("b_addr", bus.b_addr, (job_bb + n_br) % 256);
                baddr_log.push_back(int'(bus.b_addr));
                n_br++;
                chk("b_bound", n_br <= job_rows, 1);
                chk("b_credit", (n_br - (n_hs + int'(hs_now)) / job_beats) <= 2, 1);
            end
            if (hs_now) begin
                hs_log.push_back(act);
                n_hs++;
                if (exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) done_pend = 1;
                end
            end
            stall = bus.out_valid && !bus.out_ready;
            held  = act;
        end
    end

    task automatic start_job(int rows, int beats, int wb, int bb, bit rnd);
        build(rows, beats, wb, bb);
        job_wb = wb; job_bb = bb; job_beats = (beats > 0) ? beats : 1;
        job_words = (rows * beats + BPW - 1) / BPW;
        job_rows  = (rows * beats == 0) ? 0 : rows;
        n_wr = 0; n_br = 0; n_hs = 0; first_rel = -1; done_rel = -1;
        stall = 0; done_pend = 0;
        hs_log.delete(); waddr_log.delete(); baddr_log.delete();
        rnd_ready = rnd;
        cfg_rows = ROW_W'(rows); cfg_beats = BEAT_W'(beats);
        cfg_w_base = W_ADDR_W'(wb); cfg_b_base = B_ADDR_W'(bb);
        start = 1; chk_on = 1;
        @(posedge clk); #1;
        c0 = cyc; start = 0;
        cfg_rows = '1; cfg_beats = '1; cfg_w_base = '1; cfg_b_base = '1;
        if (rows * beats == 0) done_pend = 1;
    endtask

    task automatic wait_job(int stray);
        for (int i = 0; i < 3000 && done_rel < 0; i++) begin
            @(posedge clk); #1;
            start = (i == stray);
            if (i == stray) begin cfg_rows = 5; cfg_beats = 2; cfg_w_base = '0; cfg_b_base = '0; end
        end
        start = 0;
        if (done_rel < 0) chk("job_timeout", 0, 1);
        @(negedge clk); @(negedge clk); #1;
        chk("model_drained", exp_q.size(), 0);
        chk_on = 0; rnd_ready = 0;
    endtask

    task automatic run_job(int rows, int beats, int wb, int bb, bit rnd, int stray);
        start_job(rows, beats, wb, bb, rnd);
        wait_job(stray);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) wmem[i] = {$urandom, $urandom};
        for (int i = 0; i < 256; i++)  bmem[i] = $urandom;

        // Reset held: start toggling must have no effect
        for (int i = 0; i < 4; i++) begin
            start = i[0]; cfg_rows = 2; cfg_beats = 2;
            @(negedge clk);
            chk("rst_outs", {bus.w_en, bus.b_en, bus.out_valid, bus.out_first, bus.out_last, busy, done}, 0);
            chk("rst_data", {bus.out_data, bus.out_bias}, 0);
        end
        start = 0;
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;

        // Basic job: BPW=2, rows=2, beats=3
        run_job(2, 3, 'h10, 4, 0, -1);
        chk("basic_nw", waddr_log.size(), 3);
        if (waddr_log.size() == 3) begin
            chk("basic_wa0", waddr_log[0], 'h10);
            chk("basic_wa1", waddr_log[1], 'h11);
            chk("basic_wa2", waddr_log[2], 'h12);
        end
        chk("basic_nb", baddr_log.size(), 2);
        if (baddr_log.size() == 2) begin
            chk("basic_ba0", baddr_log[0], 4);
            chk("basic_ba1", baddr_log[1], 5);
        end
        chk("basic_first_valid_cyc", first_rel, 3);
        chk("basic_done_cyc", done_rel, 9);
        chk("basic_nbeats", hs_log.size(), 6);
        if (hs_log.size() == 6) begin
            chk("basic_first0", hs_log[0].first, 1);
            chk("basic_first1", hs_log[1].first, 0);
            chk("basic_first3", hs_log[3].first, 1);
            chk("basic_last4", hs_log[4].last, 0);
            chk("basic_last5", hs_log[5].last, 1);
            chk("basic_bias0", hs_log[0].bias, bmem[4]);
            chk("basic_bias2", hs_log[2].bias, bmem[4]);
            chk("basic_bias3", hs_log[3].bias, bmem[5]);
            chk("basic_data1", hs_log[1].data, wmem['h10][63:32]);
            chk("basic_data4", hs_log[4].data, wmem['h12][31:0]);
        end

        // Mid-word row start: rows=3, beats=3 -> 9 beats, 5 words
        run_job(3, 3, 'h20, 10, 0, -1);
        chk("mid_nbeats", hs_log.size(), 9);
        chk("mid_nw", waddr_log.size(), 5);
        if (hs_log.size() == 9) begin
            chk("mid_row1_beat0", hs_log[3].data, wmem['h21][63:32]);
            chk("mid_row1_first", hs_log[3].first, 1);
            chk("mid_final", hs_log[8].data, wmem['h24][31:0]);
            chk("mid_final_last", hs_log[8].last, 1);
        end

        // Backpressure, with a stray start mid-job, vs the same job at full rate
        run_job(3, 5, 'h40, 20, 1, 4);
        bp_log = hs_log;
        run_job(3, 5, 'h40, 20, 0, -1);
        chk("bp_nbeats", bp_log.size(), hs_log.size());
        if (bp_log.size() == hs_log.size())
            for (int i = 0; i < hs_log.size(); i++)
                chk("bp_same_seq", {bp_log[i].data, bp_log[i].bias}, {hs_log[i].data, hs_log[i].bias});

        // Empty jobs
        run_job(0, 5, 'h50, 30, 0, -1);
        chk("empty_rows_done_cyc", done_rel, 1);
        chk("empty_rows_no_valid", first_rel, -1);
        chk("empty_rows_no_reads", waddr_log.size() + baddr_log.size(), 0);
        run_job(4, 0, 'h50, 30, 0, -1);
        chk("empty_beats_done_cyc", done_rel, 1);
        chk("empty_beats_no_reads", waddr_log.size() + baddr_log.size(), 0);

        // Randomized jobs
        for (int j = 0; j < 8; j++)
            run_job($urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(0, 3000),
                    $urandom_range(0, 200), j[0], -1);

        // Reset mid-job, then a clean job from new bases
        start_job(6, 6, 'h100, 50, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        chk_on = 0; rnd_ready = 0; rst_n = 0;
        #1;
        chk("midrst_outs", {bus.w_en, bus.b_en, bus.out_valid, bus.out_first, bus.out_last, busy, done}, 0);
        chk("midrst_data", {bus.out_data, bus.out_bias}, 0);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;
        run_job(2, 4, 'h200, 60, 0, -1);
        chk("post_rst_nbeats", hs_log.size(), 8);
        chk("post_rst_wa0", (waddr_log.size() > 0) ? waddr_log[0] : -1, 'h200);
        chk("post_rst_ba0", (baddr_log.size() > 0) ? baddr_log[0] : -1, 60);
        chk("post_rst_first_valid", first_rel, 3);
        chk("post_rst_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/stream_memory_fetcher.md
# stream_memory_fetcher

Streaming weight/bias fetcher for the linear-layer datapath, successor to `memory_fetcher`. It reads a run-time sized weight matrix (rows × beats of N elements) from a 1-cycle-latency BRAM port, unpacks several beats per BRAM word, and pairs each beat with its row's bias from a separate bias BRAM. Results go to the MAC array over a valid/ready stream with full backpressure. Configuration is supplied per job through a start pulse with base addresses, so one instance serves multiple layers.

## Interface
- `BRAM_WIDTH`, 64: weight BRAM word width; must be an integer multiple of N*PRECISION.
- `N`, 4: elements per output beat.
- `PRECISION`, 8: element width in bits.
- `BIAS_PRECISION`, 32: bias width in bits.
- `MAX_M`, 64: maximum rows per job.
- `MAX_BEATS`, 64: maximum beats per row.
- `W_ADDR_W`, 12: weight BRAM address width.
- `B_ADDR_W`, 8: bias BRAM address width.
- Derived: `BPW` = BRAM_WIDTH/(N*PRECISION) beats per word; `ROW_W` = $clog2(MAX_M+1); `BEAT_W` = $clog2(MAX_BEATS+1).

Ports:
- `clk`, in, 1: clock; all logic on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: job start pulse; sampled only in IDLE.
- `cfg_rows`, in, ROW_W: number of rows M; captured on start.
- `cfg_beats`, in, BEAT_W: beats per row; captured on start.
- `cfg_w_base`, in, W_ADDR_W: first weight word address.
- `cfg_b_base`, in, B_ADDR_W: first bias address.
- `w_en`, out, 1: weight read enable.
- `w_addr`, out, W_ADDR_W: weight read address.
- `w_rdata`, in, BRAM_WIDTH: weight data, valid the cycle after `w_en`.
- `b_en`, out, 1: bias read enable.
- `b_addr`, out, B_ADDR_W: bias read address.
- `b_rdata`, in, BIAS_PRECISION: bias data, valid the cycle after `b_en`.
- `out_valid`, out, 1: beat available.
- `out_ready`, in, 1: consumer accepts the beat.
- `out_data`, out, N×PRECISION: packed as [N-1:0][PRECISION-1:0].
- `out_bias`, out, BIAS_PRECISION: bias of the current beat's row.
- `out_first`, out, 1: first beat of a row.
- `out_last`, out, 1: final beat of the job.
- `busy`, out, 1: job in progress.
- `done`, out, 1: one-cycle pulse at job completion.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE → RUN on `start` with rows>0 and beats>0.
- IDLE → FINISH on `start` with rows=0 or beats=0; no reads are issued.
- RUN → FINISH on the handshake of the beat with `out_last`.
- FINISH → IDLE after one cycle; `done`=1 only in FINISH.
- `start` in RUN or FINISH is ignored.
- Beats are linear: global beat g = r*beats + b.
  - Word address = cfg_w_base + g/BPW.
  - Lane = g%BPW; lane 0 is word bits [N*PRECISION-1:0].
  - Element i of the beat is lane bits [i*PRECISION +: PRECISION].
  - Rows may start mid-word.
  - Total words = ceil(rows*beats/BPW); unused lanes of the last word are discarded.
- Weight path:
  - 2-entry word FIFO with credit control.
  - A read is issued when occupancy + outstanding reads < 2, counting a same-cycle pop as a free credit.
  - The head word is popped when its last used lane is handshaken.
- Bias path:
  - Independent 2-entry FIFO with the same credit rule.
  - Address = cfg_b_base + r for r = 0..rows-1.
  - Popped on the handshake of a row's final beat.
- `out_valid` = head word present AND bias head present AND state RUN.
- `out_first` = (beat-in-row == 0). `out_last` = (row == rows-1 AND beat == beats-1).
- While `out_valid` && !`out_ready`, `out_data`, `out_bias`, `out_first` and `out_last` hold stable.
- `busy` = state != IDLE.
- Reset: all outputs 0, FIFOs emptied, counters cleared, state IDLE.
- Reset mid-job abandons the job; read data returning after reset is ignored.

## Timing
- Start accepted at edge 0 → `w_en`/`b_en` high in cycle 1 → data captured at the end of cycle 2 → `out_valid` first high in cycle 3.
- Throughput: 1 beat/cycle sustained for any BPW ≥ 1 while `out_ready`=1.
- `done` is high the cycle after the final handshake. Next `start` is accepted the cycle after `done`.
- `w_en` never exceeds FIFO capacity, and no read is issued beyond the job's total words or rows.

## Test plan
- **Reset:** hold `rst_n`=0, toggle `start` → all outputs 0, no `w_en`/`b_en`.
- **Basic job:** defaults (BPW=2), rows=2, beats=3, w_base=0x10, b_base=4, `out_ready`=1 →
  - `w_addr` 0x10, 0x11, 0x12; `b_addr` 4, 5.
  - Six beats in cycles 3–8; `out_first` on beats 0 and 3.
  - bias = mem[4] for beats 0–2 and mem[5] for beats 3–5.
  - `out_last` on beat 5; `done` in cycle 9.
- **Mid-word row start:** rows=3, beats=3 → row 1 beat 0 equals lane 1 of word 1; last word lane 1 is discarded; 9 beats total.
- **Backpressure:** pseudo-random `out_ready` with ~50% duty → data stable while stalled; beat sequence identical to the `out_ready`=1 run; at most 2 reads in flight/buffered.
- **Empty job:** start with rows=0 → `done` pulse in cycle 1, no reads, `out_valid` stays 0.
- **Start/reset during a job:** `start` pulsed mid-job is ignored; `rst_n` low mid-job → outputs 0 immediately; a new job after reset runs cleanly from its bases.
